// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The state encoding is common to the loader FSM and anything that inspects it.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port seen by the loader.
// master = byte source / memory side, slave = loader.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Shifts stream bytes MSB-first into a 32-bit word; word_full flags the
// byte that completes a word in the same cycle it is shifted in.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        shift,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0] byte_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (shift) begin
      word     <= {word[23:0], byte_in};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  assign word_full = shift && (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian byte stream into instruction memory,
// holding the CPU until the whole image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          err,
  output logic [ADDR_W:0] words_loaded
);

  localparam logic [CNT_W-1:0] CAPACITY = CNT_W'(2 ** ADDR_W);

  state_t            state, state_nx;
  logic [7:0]        len_hi;
  logic [CNT_W-1:0]  word_cnt;
  logic [CNT_W-1:0]  len_in;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       word;
  logic              word_full;
  logic              xfer;
  logic              restart;
  logic              last_word;

  assign xfer      = bus.in_valid && bus.in_ready;
  assign restart   = start && (state inside {IDLE, DONE, ERR});
  assign len_in    = CNT_W'({len_hi, bus.in_data});
  assign last_word = (CNT_W'(words_loaded) + CNT_W'(1)) == word_cnt;

  word_assembler u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift     (xfer && (state == DATA)),
    .clear     (restart),
    .byte_in   (bus.in_data),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    bus.in_ready = 1'b0;
    bus.mem_we   = 1'b0;
    cpu_hold     = 1'b1;
    done         = 1'b0;
    err          = 1'b0;
    case (state)
      IDLE: if (start) state_nx = LEN_HI;
      LEN_HI: begin
        bus.in_ready = 1'b1;
        if (xfer) state_nx = LEN_LO;
      end
      LEN_LO: begin
        bus.in_ready = 1'b1;
        if (xfer) begin
          if (len_in == '0)           state_nx = DONE;
          else if (len_in > CAPACITY) state_nx = ERR;
          else                        state_nx = DATA;
        end
      end
      DATA: begin
        bus.in_ready = 1'b1;
        if (word_full) state_nx = WRITE;
      end
      WRITE: begin
        bus.mem_we = 1'b1;
        state_nx   = last_word ? DONE : DATA;
      end
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_nx = LEN_HI;
      end
      ERR: begin
        err = 1'b1;
        if (start) state_nx = LEN_HI;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Address only advances between words, so the final word of a full-capacity
  // image lands on the top address without wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_hi       <= '0;
      word_cnt     <= '0;
      addr         <= '0;
      words_loaded <= '0;
    end else begin
      if (restart) begin
        addr         <= '0;
        words_loaded <= '0;
      end
      if (state == LEN_HI && xfer) len_hi   <= bus.in_data;
      if (state == LEN_LO && xfer) word_cnt <= len_in;
      if (state == WRITE) begin
        words_loaded <= words_loaded + 1'b1;
        if (!last_word) addr <= addr + 1'b1;
      end
    end
  end

  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = word;

endmodule
